video_dma_fetch_responder: RTL and testbench
============================================

// Module: video_dma_fetch_responder
// PURPOSE
//  Responder end of the video DMA fetch handshake: accepts a descriptor (source
//  word address, beat count, video RAM destination) from the DMA initiator,
//  reads the beats from backing memory one at a time, and writes each beat into
//  video RAM. It completes the transfer with a four-phase ack, plus an error flag.
//  It sits between the DMA descriptor logic and the memory-side read port.
// PARAMETERS
//  DATA_WIDTH     64  width of one beat (memory read data = video RAM write data)
//  VIDEOMEM_SIZE  18  video RAM address width; destination wraps modulo 2^VIDEOMEM_SIZE
// PORTS
//  clk           in   1              bus clock; single clock domain
//  rst           in   1              reset; asynchronous, active-high
//  fetch_req     in   1              initiator request, level; held until fetch_ack seen
//  read_from     in   16             source beat address; sampled on accept
//  length_data   in   16             beat count; sampled on accept; 0 is legal
//  write_to      in   VIDEOMEM_SIZE  first destination address; sampled on accept
//  fetch_ack     out  1              transfer complete; held until fetch_req low
//  fetch_err     out  1              valid with fetch_ack; 1 = aborted on mem_rd_err
//  busy          out  1              high in every state except IDLE
//  mem_rd_req    out  1              memory read request, held until mem_rd_gnt
//  mem_rd_addr   out  16             read beat address; stable while mem_rd_req
//  mem_rd_gnt    in   1              request accepted this cycle
//  mem_rd_valid  in   1              read data valid (one beat per grant)
//  mem_rd_data   in   DATA_WIDTH     read data
//  mem_rd_err    in   1              read failed; qualified by mem_rd_valid
//  vmem_we       out  1              video RAM write strobe, one cycle per beat
//  vmem_addr     out  VIDEOMEM_SIZE  video RAM write address
//  vmem_wdata    out  DATA_WIDTH     video RAM write data
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; internal counters 0.
//  - All outputs are registered.
//  - FSM states: IDLE, RD_REQ, RD_WAIT, DONE.
//  - IDLE:
//      - fetch_req=1 -> latch src, dst and remaining=length_data.
//      - If length_data==0 -> DONE (fetch_ack rises next cycle, fetch_err=0).
//      - Otherwise -> RD_REQ.
//  - RD_REQ:
//      - mem_rd_req=1, mem_rd_addr=src.
//      - On mem_rd_gnt -> RD_WAIT, with mem_rd_req=0 from the next cycle.
//      - Exactly one read is outstanding at a time.
//  - RD_WAIT, on mem_rd_valid & !mem_rd_err:
//      - Next cycle: vmem_we=1, vmem_addr=dst, vmem_wdata=mem_rd_data.
//      - src+=1 (16-bit wrap), dst+=1 (VIDEOMEM_SIZE wrap), remaining-=1.
//      - If remaining was 1 -> DONE, else -> RD_REQ.
//  - RD_WAIT, on mem_rd_valid & mem_rd_err:
//      - No write; fetch_err=1; -> DONE.
//      - Error takes precedence over data in the same cycle.
//  - DONE:
//      - fetch_ack=1 until fetch_req is sampled low; then -> IDLE, ack/err drop next cycle.
//      - A new request is accepted only from IDLE, so no re-trigger on a held req.
//  - Latency: grant-to-valid is unbounded; vmem_we pulses 1 cycle after each valid beat.
//  - Ignored inputs:
//      - mem_rd_valid outside RD_WAIT; mem_rd_gnt outside RD_REQ.
//      - fetch_req changes while busy (descriptor inputs are not re-sampled).
//  - Reset mid-transfer: immediate return to IDLE; in-flight read response dropped.
//  - Counters: remaining is 16-bit, so a maximum transfer is 65535 beats.
// STRUCTURE
//  - video_dma_pkg: FSM state enum (2-bit) and SRC_ADDR_W=16, LEN_W=16 constants,
//    shared with the initiator side.
//  - Single module; no sub-module warranted.
//    The address/length counters and the FSM stay inline.
// TESTING
//  1. len=0 -> no mem_rd_req, no vmem_we; fetch_ack=1 two cycles after req;
//     fetch_err=0; ack drops one cycle after fetch_req drops.
//  2. read_from=0x0100, write_to=0x00010, len=4, gnt and valid 1 cycle later ->
//     mem_rd_addr 0x100..0x103; vmem_addr 0x10..0x13 carry matching data; exactly 4 we pulses.
//  3. read_from=0xFFFF, write_to=0x3FFFF, len=2 -> read addrs 0xFFFF,0x0000;
//     write addrs 0x3FFFF,0x00000.
//  4. len=3, mem_rd_err with valid on beat 2 -> one vmem_we only;
//     fetch_ack=1 with fetch_err=1; no third mem_rd_req.
//  5. Mid-transfer reset:
//      - rst asserted during RD_WAIT of a len=8 transfer -> all outputs 0 asynchronously.
//      - A late mem_rd_valid causes no write.
//      - A new req afterwards starts cleanly.
//  6. fetch_req held 5 cycles after ack, gnt delayed 10 cycles -> mem_rd_req held
//     with a stable addr; no second transfer starts until req low then high.

Source files
------------

// File: rtl/video_dma_pkg.sv
// Shared types and widths for the video DMA fetch handshake (initiator and responder sides).
`default_nettype none

package video_dma_pkg;

  localparam int SRC_ADDR_W = 16;
  localparam int LEN_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/video_dma_fetch_responder.sv
// Responder end of the video DMA fetch: reads a descriptor's beats from memory one at a
// time, writes each into video RAM, then completes with a four-phase ack plus error flag.
`default_nettype none

module video_dma_fetch_responder
  import video_dma_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int VIDEOMEM_SIZE = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [SRC_ADDR_W-1:0]    read_from,
  input  logic [LEN_W-1:0]         length_data,
  input  logic [VIDEOMEM_SIZE-1:0] write_to,
  output logic                     fetch_ack,
  output logic                     fetch_err,
  output logic                     busy,
  output logic                     mem_rd_req,
  output logic [SRC_ADDR_W-1:0]    mem_rd_addr,
  input  logic                     mem_rd_gnt,
  input  logic                     mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]    mem_rd_data,
  input  logic                     mem_rd_err,
  output logic                     vmem_we,
  output logic [VIDEOMEM_SIZE-1:0] vmem_addr,
  output logic [DATA_WIDTH-1:0]    vmem_wdata
);

  fetch_state_e             state_q, state_d;
  logic [SRC_ADDR_W-1:0]    src_q, src_d;
  logic [VIDEOMEM_SIZE-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]         rem_q, rem_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;
  logic                     rdreq_q, rdreq_d;
  logic [SRC_ADDR_W-1:0]    rdaddr_q, rdaddr_d;
  logic                     we_q, we_d;
  logic [VIDEOMEM_SIZE-1:0] vaddr_q, vaddr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdreq_q  <= 1'b0;
      rdaddr_q <= '0;
      we_q     <= 1'b0;
      vaddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      rdreq_q  <= rdreq_d;
      rdaddr_q <= rdaddr_d;
      we_q     <= we_d;
      vaddr_q  <= vaddr_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    err_d   = err_q;
    we_d    = 1'b0;
    vaddr_d = vaddr_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          src_d   = read_from;
          dst_d   = write_to;
          rem_d   = length_data;
          err_d   = 1'b0;
          state_d = (length_data == '0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (mem_rd_gnt) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // An error beat wins over its data: nothing is written for it.
        if (mem_rd_valid) begin
          if (mem_rd_err) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            we_d    = 1'b1;
            vaddr_d = dst_q;
            wdata_d = mem_rd_data;
            src_d   = src_q + SRC_ADDR_W'(1);
            dst_d   = dst_q + VIDEOMEM_SIZE'(1);
            rem_d   = rem_q - LEN_W'(1);
            state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_RD_REQ;
          end
        end
      end
      ST_DONE: begin
        if (!fetch_req) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Request and address follow the next state so the request drops right after its grant.
    ack_d    = (state_q == ST_DONE) && fetch_req;
    busy_d   = (state_d != ST_IDLE);
    rdreq_d  = (state_d == ST_RD_REQ);
    rdaddr_d = rdreq_d ? src_d : rdaddr_q;
  end

  assign fetch_ack   = ack_q;
  assign fetch_err   = err_q;
  assign busy        = busy_q;
  assign mem_rd_req  = rdreq_q;
  assign mem_rd_addr = rdaddr_q;
  assign vmem_we     = we_q;
  assign vmem_addr   = vaddr_q;
  assign vmem_wdata  = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_video_dma_fetch_responder.sv
// Self-checking bench: directed table, hand-written corner sequences and random transfers.
`default_nettype none

module tb_video_dma_fetch_responder;

  localparam int DW = 64;
  localparam int VW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [15:0]   read_from;
  logic [15:0]   length_data;
  logic [VW-1:0] write_to;
  logic          fetch_ack, fetch_err, busy;
  logic          mem_rd_req;
  logic [15:0]   mem_rd_addr;
  logic          mem_rd_gnt, mem_rd_valid, mem_rd_err;
  logic [DW-1:0] mem_rd_data;
  logic          vmem_we;
  logic [VW-1:0] vmem_addr;
  logic [DW-1:0] vmem_wdata;

  video_dma_fetch_responder #(.DATA_WIDTH(DW), .VIDEOMEM_SIZE(VW)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .read_from(read_from),
    .length_data(length_data), .write_to(write_to), .fetch_ack(fetch_ack),
    .fetch_err(fetch_err), .busy(busy), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_gnt(mem_rd_gnt), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .mem_rd_err(mem_rd_err), .vmem_we(vmem_we), .vmem_addr(vmem_addr), .vmem_wdata(vmem_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input logic [15:0] a, input logic [31:0] s);
    return {s, ~a, a};
  endfunction

  // Memory model configuration (written by the test) and manual overrides.
  bit          auto_mem = 1'b1;
  int          gnt_dly = 0, val_dly = 0, err_beat = -1;
  logic [31:0] salt = '0;
  bit          man_gnt = 1'b0, man_valid = 1'b0, man_err = 1'b0;
  logic [63:0] man_data = '0;

  // Memory model / monitor private state.
  typedef struct packed { logic [VW-1:0] a; logic [DW-1:0] d; } wr_t;
  logic [15:0] rd_log[$];
  wr_t         wr_log[$];
  bit          pending = 1'b0;
  int          gcnt = 0, vcnt = 0, beat_no = 0;
  logic [15:0] pend_addr = '0;
  logic        prev_req = 1'b0, prev_gnt = 1'b0;
  logic [15:0] prev_addr = '0;
  int          mon_bad = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_req && prev_req && !prev_gnt && mem_rd_addr !== prev_addr) begin
        mon_bad++;
        $display("FAIL rd_addr_stable: got %h expected %h", mem_rd_addr, prev_addr);
      end
      if (mem_rd_req && pending) begin
        mon_bad++;
        $display("FAIL one_outstanding: got req=1 with read pending, expected req=0");
      end
      if (vmem_we) wr_log.push_back({vmem_addr, vmem_wdata});
    end
    prev_req  = mem_rd_req;
    prev_addr = mem_rd_addr;

    mem_rd_gnt   = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_err   = 1'b0;
    if (!fetch_req) beat_no = 0;
    if (rst) begin
      pending = 1'b0;
      gcnt    = 0;
      vcnt    = 0;
    end else if (!auto_mem) begin
      mem_rd_gnt   = man_gnt;
      mem_rd_valid = man_valid;
      mem_rd_err   = man_err;
      mem_rd_data  = man_data;
    end else if (pending) begin
      if (vcnt >= val_dly) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = beat_data(pend_addr, salt);
        mem_rd_err   = (beat_no == err_beat);
        pending      = 1'b0;
        beat_no++;
        vcnt = 0;
      end else vcnt++;
    end else if (mem_rd_req) begin
      if (gcnt >= gnt_dly) begin
        mem_rd_gnt = 1'b1;
        pend_addr  = mem_rd_addr;
        rd_log.push_back(mem_rd_addr);
        pending = 1'b1;
        gcnt    = 0;
        vcnt    = 0;
      end else gcnt++;
    end
    prev_gnt = mem_rd_gnt;
  end

  // One complete transfer, checked against a list-level model of the reads and writes.
  task automatic run_xfer(input logic [15:0] src, input logic [VW-1:0] dst, input int len,
                          input int errb, input int gd, input int vd, input int hold,
                          output int nrd, output int nwr, output logic err_o,
                          output logic [15:0] lastr, output logic [VW-1:0] lastw);
    int rs, ws, exp_rd, exp_wr, budget;
    bit seen, exp_err;
    rs = rd_log.size();
    ws = wr_log.size();
    gnt_dly = gd; val_dly = vd; err_beat = errb; salt = $urandom;
    exp_err = (errb >= 0) && (errb < len);
    exp_rd  = (len == 0) ? 0 : (exp_err ? errb + 1 : len);
    exp_wr  = exp_err ? errb : len;
    @(negedge clk);
    read_from = src; write_to = dst; length_data = len[15:0]; fetch_req = 1'b1;
    budget = len * (gd + vd + 4) + 20;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      seen = fetch_ack;
    end
    chk("ack_timeout", {63'b0, seen}, 64'd1);
    err_o = fetch_err;
    read_from = 16'($urandom); write_to = VW'($urandom); length_data = 16'($urandom);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("ack_held", {63'b0, fetch_ack}, 64'd1);
      chk("no_req_in_done", {63'b0, mem_rd_req}, 64'd0);
    end
    chk("fetch_err", {63'b0, fetch_err}, {63'b0, exp_err});
    nrd = rd_log.size() - rs;
    nwr = wr_log.size() - ws;
    chk("rd_count", 64'(nrd), 64'(exp_rd));
    chk("wr_count", 64'(nwr), 64'(exp_wr));
    for (int i = 0; i < nrd && i < exp_rd; i++)
      chk("rd_addr", 64'(rd_log[rs+i]), 64'(16'(src + 16'(i))));
    for (int i = 0; i < nwr && i < exp_wr; i++) begin
      chk("wr_addr", 64'(wr_log[ws+i].a), 64'(VW'(dst + VW'(i))));
      chk("wr_data", wr_log[ws+i].d, beat_data(16'(src + 16'(i)), salt));
    end
    lastr = (nrd > 0) ? rd_log[rs+nrd-1] : '0;
    lastw = (nwr > 0) ? wr_log[ws+nwr-1].a : '0;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("ack_drop", {63'b0, fetch_ack}, 64'd0);
    chk("err_drop", {63'b0, fetch_err}, 64'd0);
    @(negedge clk);
    chk("idle_busy", {63'b0, busy}, 64'd0);
  endtask

  typedef struct {
    logic [15:0]   src;
    logic [VW-1:0] dst;
    int            len, errb, gd, vd, hold;
    int            exp_rd, exp_wr;
    bit            exp_err;
    logic [15:0]   exp_lastr;
    logic [VW-1:0] exp_lastw;
  } vec_t;

  vec_t vecs[6];

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"},   {63'b0, fetch_ack},  64'd0);
    chk({tag, "_err"},   {63'b0, fetch_err},  64'd0);
    chk({tag, "_busy"},  {63'b0, busy},       64'd0);
    chk({tag, "_rdreq"}, {63'b0, mem_rd_req}, 64'd0);
    chk({tag, "_rdaddr"}, 64'(mem_rd_addr),   64'd0);
    chk({tag, "_we"},    {63'b0, vmem_we},    64'd0);
    chk({tag, "_vaddr"}, 64'(vmem_addr),      64'd0);
    chk({tag, "_wdata"}, vmem_wdata,          64'd0);
  endtask

  initial begin
    int nrd, nwr, wsz;
    logic err_o;
    logic [15:0] lastr;
    logic [VW-1:0] lastw;
    bit seen;

    vecs[0] = '{16'h0100, 18'h00010, 4, -1, 0, 0, 0, 4, 4, 1'b0, 16'h0103, 18'h00013};
    vecs[1] = '{16'hFFFF, 18'h3FFFF, 2, -1, 0, 0, 0, 2, 2, 1'b0, 16'h0000, 18'h00000};
    vecs[2] = '{16'h0200, 18'h00100, 3,  1, 0, 1, 0, 2, 1, 1'b1, 16'h0201, 18'h00100};
    vecs[3] = '{16'h0300, 18'h00000, 0, -1, 0, 0, 0, 0, 0, 1'b0, 16'h0000, 18'h00000};
    vecs[4] = '{16'h1234, 18'h20000, 5,  0, 2, 3, 1, 1, 0, 1'b1, 16'h1234, 18'h00000};
    vecs[5] = '{16'h0500, 18'h00500, 3, -1, 10, 0, 5, 3, 3, 1'b0, 16'h0502, 18'h00502};

    rst = 1'b1; fetch_req = 1'b0; read_from = '0; length_data = '0; write_to = '0;
    mem_rd_data = '0;
    #1;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Zero-length descriptor: exact ack timing, no memory traffic.
    @(negedge clk);
    read_from = 16'h0AAA; write_to = 18'h01111; length_data = 16'd0; fetch_req = 1'b1;
    @(negedge clk);
    chk("len0_ack_c1", {63'b0, fetch_ack}, 64'd0);
    chk("len0_busy_c1", {63'b0, busy}, 64'd1);
    @(negedge clk);
    chk("len0_ack_c2", {63'b0, fetch_ack}, 64'd1);
    chk("len0_err", {63'b0, fetch_err}, 64'd0);
    chk("len0_rdreq", {63'b0, mem_rd_req}, 64'd0);
    chk("len0_we", {63'b0, vmem_we}, 64'd0);
    fetch_req = 1'b0;
    @(negedge clk);
    chk("len0_ack_drop", {63'b0, fetch_ack}, 64'd0);
    @(negedge clk);

    foreach (vecs[k]) begin
      run_xfer(vecs[k].src, vecs[k].dst, vecs[k].len, vecs[k].errb, vecs[k].gd, vecs[k].vd,
               vecs[k].hold, nrd, nwr, err_o, lastr, lastw);
      chk("vec_rd", 64'(nrd), 64'(vecs[k].exp_rd));
      chk("vec_wr", 64'(nwr), 64'(vecs[k].exp_wr));
      chk("vec_err", {63'b0, err_o}, {63'b0, vecs[k].exp_err});
      if (vecs[k].exp_rd > 0) chk("vec_lastr", 64'(lastr), 64'(vecs[k].exp_lastr));
      if (vecs[k].exp_wr > 0) chk("vec_lastw", 64'(lastw), 64'(vecs[k].exp_lastw));
    end

    // Asynchronous reset while waiting for read data, then a stray late response.
    @(posedge clk); #1;
    auto_mem = 1'b0; man_gnt = 1'b0; man_valid = 1'b0; man_err = 1'b0;
    @(negedge clk);
    read_from = 16'h0040; write_to = 18'h00080; length_data = 16'd8; fetch_req = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = mem_rd_req;
    end
    chk("rst_seq_req", {63'b0, seen}, 64'd1);
    chk("rst_seq_addr", 64'(mem_rd_addr), 64'h40);
    @(posedge clk); #1 man_gnt = 1'b1;
    @(posedge clk); #1 man_gnt = 1'b0;
    chk("rst_seq_req_drop", {63'b0, mem_rd_req}, 64'd0);
    chk("rst_seq_busy", {63'b0, busy}, 64'd1);
    @(negedge clk); #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    fetch_req = 1'b0;
    man_data = 64'hDEAD_BEEF_0BAD_F00D;
    wsz = wr_log.size();
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1 man_valid = 1'b1;
    @(posedge clk); #1 man_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("late_valid_we", {63'b0, vmem_we}, 64'd0);
      chk("late_valid_busy", {63'b0, busy}, 64'd0);
    end
    chk("late_valid_nowrite", 64'(wr_log.size()), 64'(wsz));
    @(posedge clk); #1 auto_mem = 1'b1;
    run_xfer(16'h0040, 18'h00080, 8, -1, 0, 0, 0, nrd, nwr, err_o, lastr, lastw);

    // Random descriptors and memory timing.
    for (int t = 0; t < 16; t++) begin
      logic [15:0] s;
      logic [VW-1:0] d;
      int ln, eb;
      s  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(0, 7))) : 16'($urandom);
      d  = ($urandom_range(0, 3) == 0) ? VW'(18'h3FFF8 + VW'($urandom_range(0, 7))) : VW'($urandom);
      ln = $urandom_range(0, 12);
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1;
      run_xfer(s, d, ln, eb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
               nrd, nwr, err_o, lastr, lastw);
    end

    chk("monitor_protocol", 64'(mon_bad), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
